// File: rtl/vrf_port_release_unit_if.sv
// vrf_port_release_unit_if
//   Bundles the allocator handshake, the lane beat strobes and the release
//   outputs of vrf_port_release_unit. The signals keep the unit's original
//   port names so that existing connection lists still map onto them.
//   master : allocator / lanes side (drives allocation, beats and flush)
//   slave  : vrf_port_release_unit (drives ready, free pulses, busy, err)
interface vrf_port_release_unit_if #(
  parameter int unsigned R_PORTS_NUM = 8,
  parameter int unsigned W_PORTS_NUM = 4,
  parameter int unsigned CNT_W       = 12
);
  logic                   alloc_vld_i;
  logic                   alloc_rdy_o;
  logic [R_PORTS_NUM-1:0] r_port_en_i;
  logic [W_PORTS_NUM-1:0] w_port_en_i;
  logic [CNT_W-1:0]       alloc_beats_i;
  logic [R_PORTS_NUM-1:0] r_beat_i;
  logic [W_PORTS_NUM-1:0] w_beat_i;
  logic                   flush_i;
  logic [R_PORTS_NUM-1:0] free_r_port_o;
  logic [W_PORTS_NUM-1:0] free_w_port_o;
  logic [R_PORTS_NUM-1:0] busy_r_o;
  logic [W_PORTS_NUM-1:0] busy_w_o;
  logic                   err_o;

  modport master (
    output alloc_vld_i, r_port_en_i, w_port_en_i, alloc_beats_i,
           r_beat_i, w_beat_i, flush_i,
    input  alloc_rdy_o, free_r_port_o, free_w_port_o, busy_r_o, busy_w_o, err_o
  );

  modport slave (
    input  alloc_vld_i, r_port_en_i, w_port_en_i, alloc_beats_i,
           r_beat_i, w_beat_i, flush_i,
    output alloc_rdy_o, free_r_port_o, free_w_port_o, busy_r_o, busy_w_o, err_o
  );
endinterface

// File: rtl/vrf_port_release_unit.sv
// vrf_port_release_unit
//   Tracks the outstanding data beats of every VRF read/write port handed out
//   by the resource allocator and emits one-cycle release pulses when a
//   port's work completes (last beat, zero-beat allocation, or flush).
// Ports:
//   clk   : clock
//   rstn  : synchronous active-low reset
//   bus   : vrf_port_release_unit_if.slave
//           alloc_vld_i/alloc_rdy_o  allocation handshake (rdy combinational)
//           r/w_port_en_i            ports granted by the allocation
//           alloc_beats_i            beats per granted port
//           r/w_beat_i               per-port beat strobes
//           flush_i                  abort all outstanding work
//           free_r/w_port_o          registered one-cycle release pulses
//           busy_r/w_o               per-port counter non-zero
//           err_o                    sticky protocol error
// Configuration:
//   VRF_RELEASE_ERR_EN  when defined, err_o flags idle-port beats and a
//                       stalled allocation (>64 cycles); otherwise err_o = 0.
module vrf_port_release_unit #(
  parameter int unsigned R_PORTS_NUM = 8,
  parameter int unsigned W_PORTS_NUM = 4,
  parameter int unsigned CNT_W       = 12
) (
  input logic                    clk,
  input logic                    rstn,
  vrf_port_release_unit_if.slave bus
);

  logic [CNT_W-1:0]       r_cnt_q [R_PORTS_NUM];
  logic [CNT_W-1:0]       r_cnt_d [R_PORTS_NUM];
  logic [CNT_W-1:0]       w_cnt_q [W_PORTS_NUM];
  logic [CNT_W-1:0]       w_cnt_d [W_PORTS_NUM];
  logic [R_PORTS_NUM-1:0] r_free_q, r_free_d, r_busy;
  logic [W_PORTS_NUM-1:0] w_free_q, w_free_d, w_busy;
  logic                   rdy;
  logic                   accept;
  logic                   zero_beats;

  always_comb begin
    r_busy = '0;
    for (int unsigned i = 0; i < R_PORTS_NUM; i++) r_busy[i] = (r_cnt_q[i] != '0);
    w_busy = '0;
    for (int unsigned i = 0; i < W_PORTS_NUM; i++) w_busy[i] = (w_cnt_q[i] != '0);
  end

  // A port taking its final beat this cycle is still busy, so a same-cycle
  // re-allocation of it is held off until the next cycle.
  assign rdy = !bus.flush_i
             && ((bus.r_port_en_i & r_busy) == '0)
             && ((bus.w_port_en_i & w_busy) == '0);
  assign accept     = bus.alloc_vld_i && rdy;
  assign zero_beats = (bus.alloc_beats_i == '0);

  // Accepted ports are idle by construction, so a load never collides with a
  // decrement on the same port; a beat on such a port is simply dropped.
  always_comb begin
    r_cnt_d  = r_cnt_q;
    r_free_d = '0;
    for (int unsigned i = 0; i < R_PORTS_NUM; i++) begin
      if (bus.flush_i) begin
        r_cnt_d[i]  = '0;
        r_free_d[i] = r_busy[i];
      end else begin
        if (bus.r_beat_i[i] && r_busy[i]) begin
          r_cnt_d[i]  = r_cnt_q[i] - CNT_W'(1);
          r_free_d[i] = (r_cnt_q[i] == CNT_W'(1));
        end
        if (accept && bus.r_port_en_i[i]) begin
          if (zero_beats) r_free_d[i] = 1'b1;
          else            r_cnt_d[i]  = bus.alloc_beats_i;
        end
      end
    end
  end

  always_comb begin
    w_cnt_d  = w_cnt_q;
    w_free_d = '0;
    for (int unsigned i = 0; i < W_PORTS_NUM; i++) begin
      if (bus.flush_i) begin
        w_cnt_d[i]  = '0;
        w_free_d[i] = w_busy[i];
      end else begin
        if (bus.w_beat_i[i] && w_busy[i]) begin
          w_cnt_d[i]  = w_cnt_q[i] - CNT_W'(1);
          w_free_d[i] = (w_cnt_q[i] == CNT_W'(1));
        end
        if (accept && bus.w_port_en_i[i]) begin
          if (zero_beats) w_free_d[i] = 1'b1;
          else            w_cnt_d[i]  = bus.alloc_beats_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < R_PORTS_NUM; i++) r_cnt_q[i] <= '0;
      for (int unsigned i = 0; i < W_PORTS_NUM; i++) w_cnt_q[i] <= '0;
      r_free_q <= '0;
      w_free_q <= '0;
    end else begin
      r_cnt_q  <= r_cnt_d;
      w_cnt_q  <= w_cnt_d;
      r_free_q <= r_free_d;
      w_free_q <= w_free_d;
    end
  end

  assign bus.alloc_rdy_o   = rdy;
  assign bus.free_r_port_o = r_free_q;
  assign bus.free_w_port_o = w_free_q;
  assign bus.busy_r_o      = r_busy;
  assign bus.busy_w_o      = w_busy;

`ifdef VRF_RELEASE_ERR_EN
  logic [6:0] wd_q;
  logic       err_q;
  logic       idle_beat;
  logic       stall;

  assign idle_beat = !bus.flush_i
                   && (((bus.r_beat_i & ~r_busy) != '0) || ((bus.w_beat_i & ~w_busy) != '0));
  assign stall     = bus.alloc_vld_i
                   && (((bus.r_port_en_i & r_busy) != '0) || ((bus.w_port_en_i & w_busy) != '0));

  // wd_q counts preceding consecutive stall cycles and saturates at 64; a
  // stall seen with wd_q == 64 is the 65th in a row.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (!stall)             wd_q <= '0;
      else if (wd_q != 7'd64) wd_q <= wd_q + 7'd1;
      err_q <= err_q | idle_beat | (stall && (wd_q == 7'd64));
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vrf_port_release_unit.sv
module tb_vrf_port_release_unit;

`ifdef VRF_RELEASE_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk;
  logic rstn;
  int   vectors;
  int   miscompares;

  vrf_port_release_unit_if #(.R_PORTS_NUM(8), .W_PORTS_NUM(4), .CNT_W(12)) bus_if ();

  vrf_port_release_unit #(.R_PORTS_NUM(8), .W_PORTS_NUM(4), .CNT_W(12)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.alloc_vld_i   = 1'b0;
    bus_if.r_port_en_i   = '0;
    bus_if.w_port_en_i   = '0;
    bus_if.alloc_beats_i = '0;
    bus_if.r_beat_i      = '0;
    bus_if.w_beat_i      = '0;
    bus_if.flush_i       = 1'b0;
  endtask

  task automatic alloc(input logic [7:0] ren, input logic [3:0] wen, input logic [11:0] beats);
    bus_if.alloc_vld_i   = 1'b1;
    bus_if.r_port_en_i   = ren;
    bus_if.w_port_en_i   = wen;
    bus_if.alloc_beats_i = beats;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;

    // Reset state
    chk("rst_busy_r", bus_if.busy_r_o, 8'h00);
    chk("rst_busy_w", bus_if.busy_w_o, 4'h0);
    chk("rst_free_r", bus_if.free_r_port_o, 8'h00);
    chk("rst_free_w", bus_if.free_w_port_o, 4'h0);
    chk("rst_err", bus_if.err_o, 1'b0);
    #1 chk("rst_rdy", bus_if.alloc_rdy_o, 1'b1);
    bus_if.flush_i = 1'b1;
    #1 chk("rdy_flush_no_en", bus_if.alloc_rdy_o, 1'b0);
    bus_if.flush_i = 1'b0;
    #1 chk("rdy_no_en", bus_if.alloc_rdy_o, 1'b1);

    // Basic read-port release: r0,r1 with 4 beats
    alloc(8'h03, 4'h0, 12'd4);
    #1 chk("basic_rdy", bus_if.alloc_rdy_o, 1'b1);
    tick();
    idle();
    chk("basic_busy_load", bus_if.busy_r_o, 8'h03);
    chk("basic_free_load", bus_if.free_r_port_o, 8'h00);
    bus_if.r_port_en_i = 8'h01;
    #1 chk("basic_rdy_busy_port", bus_if.alloc_rdy_o, 1'b0);
    bus_if.r_port_en_i = 8'h04;
    #1 chk("basic_rdy_other_port", bus_if.alloc_rdy_o, 1'b1);
    bus_if.r_port_en_i = 8'h00;
    for (int k = 1; k <= 4; k++) begin
      bus_if.r_beat_i = 8'h03;
      tick();
      chk("basic_free_beat", bus_if.free_r_port_o, (k == 4) ? 8'h03 : 8'h00);
      chk("basic_busy_beat", bus_if.busy_r_o, (k == 4) ? 8'h00 : 8'h03);
    end
    bus_if.r_beat_i = 8'h00;
    tick();
    chk("basic_free_one_cycle", bus_if.free_r_port_o, 8'h00);

    // Zero-beat allocation on w2
    alloc(8'h00, 4'h4, 12'd0);
    tick();
    idle();
    chk("zero_free_w", bus_if.free_w_port_o, 4'h4);
    chk("zero_busy_w", bus_if.busy_w_o, 4'h0);
    tick();
    chk("zero_free_w_end", bus_if.free_w_port_o, 4'h0);
    chk("zero_busy_w_end", bus_if.busy_w_o, 4'h0);

    // Back-to-back on w0
    alloc(8'h00, 4'h1, 12'd2);
    tick();
    idle();
    chk("b2b_busy_load", bus_if.busy_w_o, 4'h1);
    bus_if.w_beat_i = 4'h1;
    tick();
    alloc(8'h00, 4'h1, 12'd3);
    bus_if.w_beat_i = 4'h1;
    #1 chk("b2b_rdy_T", bus_if.alloc_rdy_o, 1'b0);
    tick();
    bus_if.w_beat_i = 4'h0;
    chk("b2b_free_T1", bus_if.free_w_port_o, 4'h1);
    chk("b2b_busy_T1", bus_if.busy_w_o, 4'h0);
    #1 chk("b2b_rdy_T1", bus_if.alloc_rdy_o, 1'b1);
    tick();
    idle();
    chk("b2b_busy_reload", bus_if.busy_w_o, 4'h1);
    chk("b2b_free_reload", bus_if.free_w_port_o, 4'h0);
    for (int k = 1; k <= 3; k++) begin
      bus_if.w_beat_i = 4'h1;
      tick();
      chk("b2b_free_count", bus_if.free_w_port_o, (k == 3) ? 4'h1 : 4'h0);
    end
    bus_if.w_beat_i = 4'h0;
    tick();

    // Flush with r2 at 5 and w1 at 3; beat on r2 during flush is ignored
    alloc(8'h04, 4'h0, 12'd5);
    tick();
    alloc(8'h00, 4'h2, 12'd3);
    tick();
    idle();
    chk("flush_busy_r_pre", bus_if.busy_r_o, 8'h04);
    chk("flush_busy_w_pre", bus_if.busy_w_o, 4'h2);
    bus_if.flush_i  = 1'b1;
    bus_if.r_beat_i = 8'h04;
    #1 chk("flush_rdy", bus_if.alloc_rdy_o, 1'b0);
    tick();
    idle();
    chk("flush_free_r", bus_if.free_r_port_o, 8'h04);
    chk("flush_free_w", bus_if.free_w_port_o, 4'h2);
    chk("flush_busy_r", bus_if.busy_r_o, 8'h00);
    chk("flush_busy_w", bus_if.busy_w_o, 4'h0);
    tick();
    chk("flush_free_r_end", bus_if.free_r_port_o, 8'h00);
    chk("flush_free_w_end", bus_if.free_w_port_o, 4'h0);
    chk("flush_no_err", bus_if.err_o, 1'b0);

    // Reset mid-operation with r0, r1, w3 busy
    alloc(8'h03, 4'h8, 12'd10);
    tick();
    idle();
    chk("mid_busy_r", bus_if.busy_r_o, 8'h03);
    chk("mid_busy_w", bus_if.busy_w_o, 4'h8);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("mid_rst_busy_r", bus_if.busy_r_o, 8'h00);
    chk("mid_rst_busy_w", bus_if.busy_w_o, 4'h0);
    chk("mid_rst_free_r", bus_if.free_r_port_o, 8'h00);
    chk("mid_rst_free_w", bus_if.free_w_port_o, 4'h0);
    chk("mid_rst_err", bus_if.err_o, 1'b0);
    tick();
    chk("mid_post_free_r", bus_if.free_r_port_o, 8'h00);
    chk("mid_post_free_w", bus_if.free_w_port_o, 4'h0);

    // Beat on idle r5
    bus_if.r_beat_i = 8'h20;
    tick();
    bus_if.r_beat_i = 8'h00;
    chk("err_set", bus_if.err_o, ERR_EXP);
    chk("err_no_free", bus_if.free_r_port_o, 8'h00);
    tick();
    tick();
    chk("err_sticky", bus_if.err_o, ERR_EXP);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("err_cleared", bus_if.err_o, 1'b0);

    // Full-scale beat count on w3: no wrap, release only on the 4095th beat
    alloc(8'h00, 4'h8, 12'hFFF);
    tick();
    idle();
    chk("max_busy_load", bus_if.busy_w_o, 4'h8);
    bus_if.w_beat_i = 4'h8;
    for (int k = 1; k <= 4094; k++) tick();
    chk("max_busy_4094", bus_if.busy_w_o, 4'h8);
    chk("max_free_4094", bus_if.free_w_port_o, 4'h0);
    tick();
    bus_if.w_beat_i = 4'h0;
    chk("max_free_4095", bus_if.free_w_port_o, 4'h8);
    chk("max_busy_4095", bus_if.busy_w_o, 4'h0);
    tick();
    chk("max_free_end", bus_if.free_w_port_o, 4'h0);
    chk("max_err", bus_if.err_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vrf_port_release_unit.md
# vrf_port_release_unit

Tracks every VRF read and write port handed out by the vector control unit's resource allocator. It counts the data beats each port still owes and emits one-cycle free pulses when a port's work completes. It sits directly downstream of the allocator: it consumes the allocation handshake and the port-enable vectors, and it drives the allocator's `free_r_port_i` / `free_w_port_i` and `alloc_resources_rdy_i`.

## Interface
- `R_PORTS_NUM`, 8, number of VRF read ports.
- `W_PORTS_NUM`, 4, number of VRF write ports.
- `CNT_W`, 12, width of the per-port beat counter.

- `clk`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `alloc_vld_i`  in  1  allocator offers an allocation.
- `alloc_rdy_o`  out  1  allocation may be accepted this cycle.
- `r_port_en_i`  in  R_PORTS_NUM  read ports granted by this allocation.
- `w_port_en_i`  in  W_PORTS_NUM  write ports granted by this allocation.
- `alloc_beats_i`  in  CNT_W  beats each granted port must transfer.
- `r_beat_i`  in  R_PORTS_NUM  per-port read beat strobe from the lanes.
- `w_beat_i`  in  W_PORTS_NUM  per-port write beat strobe from the lanes.
- `flush_i`  in  1  abort all outstanding work.
- `free_r_port_o`  out  R_PORTS_NUM  one-cycle release pulse per read port.
- `free_w_port_o`  out  W_PORTS_NUM  one-cycle release pulse per write port.
- `busy_r_o`  out  R_PORTS_NUM  read port counter is non-zero.
- `busy_w_o`  out  W_PORTS_NUM  write port counter is non-zero.
- `err_o`  out  1  sticky protocol error (see Configuration).

## Operation
- **Per-port state**
  - Each port has a counter `cnt[CNT_W]` and a registered free pulse.
  - `busy = (cnt != 0)`.
- **Ready**
  - `alloc_rdy_o` is combinational: high when no port enabled in `r_port_en_i` / `w_port_en_i` is busy and `flush_i` is low.
  - When all enables are zero, `alloc_rdy_o` is high unless `flush_i` is high.
- **Accept**
  - An allocation is accepted when `alloc_vld_i && alloc_rdy_o`.
  - Every enabled port loads `cnt <= alloc_beats_i`.
  - If `alloc_beats_i == 0`, no load occurs. Instead, each enabled port's free pulse is asserted the next cycle.
- **Beats**
  - A beat on a busy port decrements `cnt`.
  - A beat that takes `cnt` from 1 to 0 sets that port's free pulse for the next cycle.
  - A beat on an idle port is ignored and flagged as an error.
- **Flush**
  - `flush_i` zeroes all counters.
  - Every port that was busy at flush gets a free pulse the next cycle.
  - Beats in the flush cycle are ignored and are not flagged.
- **Counter rules**
  - Counters never underflow.
  - No wrap: `alloc_beats_i` is taken as an unsigned value up to 2^CNT_W−1.
- **Simultaneous events**
  - The final beat and a new allocation for the same port in the same cycle: the port still counts as busy, so `alloc_rdy_o` is low. The allocation is accepted at the earliest the cycle after.
  - Different ports are fully independent.
- **Reset**
  - Counters are 0, all free pulses are 0, `err_o` is 0, all `busy_*` are 0.
  - `alloc_rdy_o` follows its combinational rule: it is 1 when `flush_i` is low.
  - Reset mid-operation discards all outstanding beats and emits no free pulses.

## Timing
- Allocation accepted in cycle T: counters are loaded at the T+1 edge, and `busy_*` is high from T+1.
- A beat presented in cycle T on a port accepted in cycle T counts as an idle-port beat.
- Final beat in cycle T: `cnt == 0` and `free_*_o` high during T+1 only. `alloc_rdy_o` for that port can rise in T+1.
- Zero-beat allocation accepted in T: free pulse in T+1.
- Flush in T: free pulses in T+1.
- Free pulses are always exactly one cycle wide.

## Configuration
- Macro: `VRF_RELEASE_ERR_EN`.
- **With the macro defined:** `err_o` sets and stays high until reset on any of:
  - a beat on an idle port outside a flush cycle;
  - `alloc_vld_i` high with an enabled port busy for more than 64 consecutive cycles (stall watchdog, 7-bit counter).
- **Without the macro:** `err_o` is tied to 0. The watchdog and error logic are not synthesized. Functional behaviour is otherwise identical.

## Test plan
- **Basic read-port release:** accept `r_port_en=0b0000_0011`, `beats=4`; pulse `r_beat[0]` and `r_beat[1]` 4 times each → `free_r_port_o = 0b11` for exactly one cycle after the 4th beat, `busy_r_o = 0`.
- **Zero-beat allocation:** accept `w_port_en=0b0100`, `beats=0` → `free_w_port_o = 0b0100` in the next cycle; `busy_w_o` never rises.
- **Back-to-back on the same port:** issue the final beat on w0 in cycle T with `alloc_vld` requesting w0 → `alloc_rdy_o = 0` in T and `1` in T+1; the new allocation is accepted in T+1 with `cnt = beats`.
- **Flush:** with r2 at `cnt=5` and w1 at `cnt=3`, assert `flush_i` → `alloc_rdy_o = 0` that cycle; `free_r_port_o[2]` and `free_w_port_o[1]` pulse next cycle; all counters are 0.
- **Reset mid-operation:** with 3 ports busy, hold `rstn = 0` for one cycle → no free pulses, all `busy = 0`, `err_o = 0`.
- **Error flag (`VRF_RELEASE_ERR_EN` defined):** `r_beat[5]` on idle r5 → `err_o = 1` from the next cycle until reset. Without the macro, the same stimulus gives `err_o = 0`.
